// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver:
// FSM state encoding, frame length and the odd-parity helper.
package ps2_pkg;

  // Host-to-device transfer phases, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_WAIT_IDLE = 3'd6,
    ST_DONE      = 3'd7
  } ps2State_t;

  // Start, eight data bits, parity, stop.
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity: the nine bits data+parity hold an odd number of ones.
  function automatic logic oddParity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Frame as it appears on the wire, bit 0 first: start 0, D0..D7, parity, stop 1.
  function automatic logic [PS2_FRAME_BITS-1:0] buildFrame(input logic [7:0] d);
    return {1'b1, oddParity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_fall_detect.sv
// Registered falling-edge detector for an already synchronised PS/2 line.
// The pulse appears one clk after the line is first seen low, so a consumer
// that registers its response lands two clk cycles after the line fell.
module ps2_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic fall
);

  logic prevLevel;

  // Remember the previous level and flag a high-to-low transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevLevel <= 1'b0;
      fall      <= 1'b0;
    end else begin
      prevLevel <= level;
      fall      <= prevLevel & ~level;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over the open-drain clock/data pair. Outputs are open-drain enables
// (1 = pull the line low); all outputs are registered.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog on device clocking.
//
// Handshake: txData is taken on a rising clk edge where txValid && txReady;
// txReady is high only while idle, so a request raised during a transfer
// simply waits until the block returns to idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1350,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output ps2State_t  dbgState
);

  localparam logic [15:0] INH_LAST = 16'(INHIBIT_CYCLES - 1);

  ps2State_t                 state, stateNext;
  logic [15:0]               inhCnt, inhCntNext;
  logic [3:0]                bitCnt, bitCntNext;
  logic [PS2_FRAME_BITS-1:0] frameReg, frameNext;
  logic                      dataOeQ, dataOeNext;
  logic                      errFlag, errNext;
  logic                      clkOeQ, readyQ, busyQ, doneQ, errorQ;
  logic                      fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdCnt, wdCntNext;
  logic        wdActive;
`endif

  ps2_fall_detect uFall (
    .clk   (clk),
    .reset (reset),
    .level (ps2Clk),
    .fall  (fall)
  );

  // State, counters, frame and registered line/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      inhCnt   <= '0;
      bitCnt   <= '0;
      frameReg <= '0;
      dataOeQ  <= 1'b0;
      errFlag  <= 1'b0;
      clkOeQ   <= 1'b0;
      readyQ   <= 1'b1;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      errorQ   <= 1'b0;
    end else begin
      state    <= stateNext;
      inhCnt   <= inhCntNext;
      bitCnt   <= bitCntNext;
      frameReg <= frameNext;
      dataOeQ  <= dataOeNext;
      errFlag  <= errNext;
      clkOeQ   <= (stateNext == ST_INHIBIT);
      readyQ   <= (stateNext == ST_IDLE);
      busyQ    <= (stateNext != ST_IDLE) && (stateNext != ST_DONE);
      doneQ    <= (stateNext == ST_DONE);
      errorQ   <= (stateNext == ST_DONE) && errNext;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  // Watchdog counter: restarts on every device clock edge and on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wdCnt <= '0;
    else        wdCnt <= wdCntNext;
  end
`endif

  // Next-state and next-output logic for the transfer sequence.
  always_comb begin
    stateNext  = state;
    inhCntNext = inhCnt;
    bitCntNext = bitCnt;
    frameNext  = frameReg;
    dataOeNext = dataOeQ;
    errNext    = errFlag;

    case (state)
      ST_IDLE: begin
        if (txValid && txReady) begin
          stateNext  = ST_INHIBIT;
          inhCntNext = '0;
          bitCntNext = '0;
          frameNext  = buildFrame(txData);
          errNext    = 1'b0;
          // The start bit overlaps the last inhibit cycle; with a one-cycle
          // inhibit that cycle is the very first one.
          dataOeNext = (INHIBIT_CYCLES == 1);
        end
      end

      ST_INHIBIT: begin
        if (inhCnt == INH_LAST) begin
          stateNext  = ST_START;
          inhCntNext = '0;
          dataOeNext = 1'b1;
        end else begin
          inhCntNext = inhCnt + 16'd1;
          dataOeNext = ((inhCnt + 16'd1) == INH_LAST);
        end
      end

      ST_START: begin
        if (fall) begin
          stateNext  = ST_DATA;
          bitCntNext = 4'd1;
          dataOeNext = ~frameReg[bitCntNext];
        end
      end

      ST_DATA: begin
        if (fall) begin
          bitCntNext = bitCnt + 4'd1;
          dataOeNext = ~frameReg[bitCntNext];
          // Index 8 is D7; the edge after it puts parity on the line.
          if (bitCnt == 4'd8) stateNext = ST_PARITY;
        end
      end

      ST_PARITY: begin
        if (fall) begin
          stateNext  = ST_STOP;
          bitCntNext = 4'd10;
          // Stop bit is 1, so the data line is released.
          dataOeNext = ~frameReg[bitCntNext];
        end
      end

      ST_STOP: begin
        if (fall) begin
          stateNext = ST_WAIT_IDLE;
          // Device acknowledges by holding data low on this edge.
          errNext   = ps2Data;
        end
      end

      ST_WAIT_IDLE: begin
        if (ps2Clk && ps2Data) stateNext = ST_DONE;
      end

      ST_DONE: begin
        stateNext  = ST_IDLE;
        bitCntNext = '0;
        frameNext  = '0;
        dataOeNext = 1'b0;
      end

      default: begin
        stateNext = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wdActive = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY) ||
               (state == ST_STOP) || (state == ST_WAIT_IDLE);
    // A device edge in the expiry cycle counts as progress, not a timeout.
    if (wdActive && !fall && (wdCnt == WD_LAST)) begin
      stateNext  = ST_DONE;
      dataOeNext = 1'b0;
      errNext    = 1'b1;
    end
    if (!wdActive || fall || (stateNext != state)) wdCntNext = '0;
    else                                           wdCntNext = wdCnt + 16'd1;
`endif
  end

  assign txReady   = readyQ;
  assign ps2ClkOe  = clkOeQ;
  assign ps2DataOe = dataOeQ;
  assign busy      = busyQ;
  assign done      = doneQ;
  assign error     = errorQ;
  assign dbgState  = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 keyboard model clocks frames out of the host,
// a scoreboard queue holds the expected {error, frame} per transfer and a
// monitor compares each done pulse against it.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 1350;
  localparam int TMO  = 27000;
  localparam int HALF = 10;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       devClk  = 1'b1;
  logic       devData = 1'b1;
  logic [7:0] txData  = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady, ps2ClkOe, ps2DataOe, busy, done, error;
  ps2State_t  dbgState;

  // Open-drain wired-AND of host and device on each line.
  logic clkLine, dataLine;
  assign clkLine  = devClk & ~ps2ClkOe;
  assign dataLine = devData & ~ps2DataOe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2Clk    (clkLine),
    .ps2Data   (dataLine),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .ps2ClkOe  (ps2ClkOe),
    .ps2DataOe (ps2DataOe),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbgState  (dbgState)
  );

  // ---------------- scoreboard state ----------------
  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [11:0] exp_q[$];
  logic [10:0] capFrame  = '0;
  logic        devAck    = 1'b1;
  logic        devMute   = 1'b0;
  logic        devBusy   = 1'b0;
  int          fallCount = 0;
  int          doneCount = 0;
  int          cycle     = 0;
  int          inhLen = 0, lastInhLen = 0, overlap = 0, readyViol = 0;
  int          startCycle = 0, doneCycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        if (ps2ClkOe) begin
          inhLen++;
          if (ps2DataOe) overlap++;
        end else if (inhLen != 0) begin
          lastInhLen = inhLen;
          inhLen     = 0;
          startCycle = cycle;
        end
        if (busy && txReady) readyViol++;
        if (done) begin
          doneCount++;
          doneCycle = cycle;
          check("done_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_and_error", {error, capFrame}, e);
            check("clk_oe_at_done", ps2ClkOe, 0);
            check("data_oe_at_done", ps2DataOe, 0);
          end
        end
      end
    end
  end

  // ---------------- keyboard model ----------------
  initial begin : device
    forever begin
      @(negedge clk);
      if (ps2ClkOe && !devMute) begin
        devBusy = 1'b1;
        for (int w = 0; w < INH + 100 && ps2ClkOe; w++) @(negedge clk);
        check("inhibit_release", ps2ClkOe, 0);
        fallCount = 0;
        for (int i = 0; i < 11; i++) begin
          repeat (HALF) @(negedge clk);
          capFrame[i] = dataLine;
          devClk = 1'b0;
          fallCount++;
          if (i == 10 && devAck) devData = 1'b0;
          repeat (HALF) @(negedge clk);
          devClk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        devData = 1'b1;
        devBusy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sendByte(input logic [7:0] d, input logic [11:0] exp, input bit track);
    int w;
    txData  = d;
    txValid = 1'b1;
    w = 0;
    while (!txReady && w < 50000) begin
      @(negedge clk);
      w++;
    end
    if (track) exp_q.push_back(exp);
    @(negedge clk);
    txValid = 1'b0;
    check("accept_clk_oe", ps2ClkOe, 1);
  endtask

  task automatic waitDone(input int target);
    int w;
    w = 0;
    while (doneCount < target && w < 40000) begin
      @(negedge clk);
      w++;
    end
    check("done_count", doneCount, target);
    w = 0;
    while (devBusy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : main
    int w;
    int doneBefore;

    repeat (3) @(negedge clk);
    check("rst_ready", txReady, 1);
    check("rst_clk_oe", ps2ClkOe, 0);
    check("rst_data_oe", ps2DataOe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_state", dbgState, ST_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xED with ACK: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    devAck = 1'b1;
    sendByte(8'hED, 12'h7DA, 1'b1);
    waitDone(1);
    check("inhibit_len", lastInhLen, INH);
    check("start_overlap", overlap, 1);

    // 0x01 then 0xFF with txValid held: parity 0 then 1.
    txData  = 8'h01;
    txValid = 1'b1;
    w = 0;
    while (!txReady && w < 100) begin @(negedge clk); w++; end
    exp_q.push_back(12'h402);
    @(posedge clk);
    #1 txData = 8'hFF;
    w = 0;
    while (!txReady && w < 50000) begin @(negedge clk); w++; end
    check("b2b_done_first", doneCount, 2);
    exp_q.push_back(12'h7FE);
    @(posedge clk);
    #1 txValid = 1'b0;
    waitDone(3);

    // 0xF4 with no ACK: parity 0, error expected.
    devAck = 1'b0;
    sendByte(8'hF4, 12'hDE8, 1'b1);
    waitDone(4);
    devAck = 1'b1;

    // Reset after D3 of 0x12 is on the line (D3 = 0, so data is pulled low).
    fallCount = 0;
    sendByte(8'h12, 12'h000, 1'b0);
    w = 0;
    while (fallCount < 4 && w < 5000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    check("d3_driven", ps2DataOe, 1);
    doneBefore = doneCount;
    reset = 1'b0;
    #1;
    check("abort_clk_oe", ps2ClkOe, 0);
    check("abort_data_oe", ps2DataOe, 0);
    check("abort_ready", txReady, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle", dbgState, ST_IDLE);
    w = 0;
    while (devBusy && w < 1000) begin @(negedge clk); w++; end
    repeat (20) @(negedge clk);
    check("abort_no_done", doneCount, doneBefore);
    check("abort_ready_after", txReady, 1);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog fires TMO cycles after START is entered.
    devMute  = 1'b1;
    capFrame = '0;
    sendByte(8'hFF, 12'h800, 1'b1);
    waitDone(doneBefore + 1);
    check("timeout_latency", doneCycle - startCycle, TMO);
    devMute = 1'b0;
`endif

    check("ready_low_while_busy", readyViol, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard over the shared open-drain `ps2Clk`/`ps2Data` lines, for example 0xED to set LEDs or 0xFF to reset. It sits in the SoC next to the existing PS/2 keyboard receiver and takes the same debounced line levels. Its two open-drain enables are ANDed into the pad drivers at top level.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 1350: clock-low inhibit time, 100 µs at 13.5 MHz.
- `TIMEOUT_CYCLES`, default 27000: maximum wait for any device clock edge, 2 ms at 13.5 MHz.

Ports:
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `reset`  in  1  asynchronous reset, active-low.
- `ps2Clk`  in  1  debounced PS/2 clock level, already synchronous to `clk`.
- `ps2Data`  in  1  debounced PS/2 data level, already synchronous to `clk`.
- `txData`  in  8  command byte.
- `txValid`  in  1  request to send; the byte is accepted when `txValid && txReady`.
- `txReady`  out  1  high only in IDLE.
- `ps2ClkOe`  out  1  1 = pull PS/2 clock low.
- `ps2DataOe`  out  1  1 = pull PS/2 data low.
- `busy`  out  1  high from acceptance until DONE; the receiver discards frames while this is high.
- `done`  out  1  one-cycle pulse at the end of every transfer.
- `error`  out  1  valid only with `done`; 1 = missing ACK or timeout.

## Operation
- Reset values: state IDLE, `txReady`=1, `ps2ClkOe`=0, `ps2DataOe`=0, `busy`=0, `done`=0, `error`=0. All counters and the shift register are 0.
- Falling-edge detect: `fall = prevClk & ~ps2Clk`, where `prevClk` is `ps2Clk` registered.
- The shift register holds 11 bits: start 0, `txData[0..7]` LSB first, odd parity `~^txData`, stop 1. The ACK bit is sampled separately.

States:
- IDLE: on accept, latch the frame and go to INHIBIT. A `txValid` seen in any other state is ignored; it stays pending because `txReady` is low.
- INHIBIT: `ps2ClkOe`=1. Count `INHIBIT_CYCLES`. In the last counted cycle, set `ps2DataOe`=1 (start bit) and go to START.
- START: `ps2ClkOe`=0, `ps2DataOe`=1. On the first `fall`, drive D0 and go to DATA.
- DATA: on each `fall`, shift out the next bit. `ps2DataOe` is the inverse of the bit. After D7 has been driven and the next `fall` arrives, drive parity and go to PARITY.
- PARITY: on `fall`, set `ps2DataOe`=0 (stop bit) and go to STOP.
- STOP: on `fall`, sample `ps2Data`. ACK means `ps2Data`=0; then go to WAIT_IDLE. If `ps2Data`=1, set the error flag and go to WAIT_IDLE.
- WAIT_IDLE: wait until `ps2Clk`=1 and `ps2Data`=1 in the same cycle, then go to DONE.
- DONE: pulse `done`=1 with `error` for one cycle, then go to IDLE.

Boundary conditions:
- Bit count: a 4-bit counter from 0 to 10 selects the bit. Parity is computed at accept time, not per bit.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, so both lines are released immediately. No `done` pulse is produced.
- `fall` in the same cycle as a timeout expiry: the edge wins and the timeout counter clears.
- `txValid` held continuously: back-to-back transfers are accepted, one per IDLE visit. There is at least one IDLE cycle between frames.

## Timing
- Accept at cycle N: `ps2ClkOe`=1 at N+1.
- Start bit: `ps2DataOe`=1 from cycle N+`INHIBIT_CYCLES`. `ps2ClkOe` releases one cycle later.
- Data response: `ps2DataOe` changes exactly two `clk` cycles after `ps2Clk` goes low, one cycle for edge detect and one for the register update. This is well inside the device's ~30 µs clock-low half period.
- `done` arrives 2 cycles after both lines are seen high.
- Nominal frame: `INHIBIT_CYCLES` + 11 device clocks + line-release time.

## Configuration
Macro `PS2_TX_TIMEOUT_EN`:
- Defined: a 16-bit watchdog runs in START, DATA, PARITY, STOP and WAIT_IDLE. It reloads on every `fall` and on each state entry. When it reaches `TIMEOUT_CYCLES`, both OEs are released, `error`=1, and the state goes to DONE.
- Undefined: no watchdog and no counter logic. The block waits indefinitely, and `error` only reports a missing ACK.

## Structure
- Shared package `ps2_pkg`: state enum (IDLE, INHIBIT, START, DATA, PARITY, STOP, WAIT_IDLE, DONE), `PS2_FRAME_BITS`=11, and an odd-parity function. The package is shared with the receiver.
- One sub-module, `ps2_fall_detect`: a registered falling-edge detector, reusable by the receiver.

## Test plan
- Send 0xED with a device model that ACKs: the line shows data bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Expect `done`=1, `error`=0, and `ps2ClkOe` high for exactly 1350 cycles.
- Send 0x01 and then 0xFF with `txValid` held high: expect parity 0 and then 1, two `done` pulses, and `txReady` low throughout each frame.
- Device leaves data high at clock 11 (no ACK): expect `done`=1, `error`=1, and both OEs 0.
- With `PS2_TX_TIMEOUT_EN` defined, the device never clocks: expect `done`=1 and `error`=1 exactly 27000 cycles after START is entered, with the lines released.
- Assert `reset`=0 after D3 has been driven: expect `ps2ClkOe`=`ps2DataOe`=0 in the same cycle, IDLE with `txReady`=1 after release, and no `done` pulse.
